text_pixel_gen: RTL and testbench
=================================

Name: text_pixel_gen

Overview:
- Text-mode pixel generator that sits directly downstream of CRTC and consumes its timing outputs (col_stb, col, line, cursor, hsync, vsync, video_on).
- Per character cell: fetches the char/attribute word from video RAM, then the glyph row from the font ROM, then serialises 8 pixels through a 16-entry palette.
- Delays hsync/vsync so the syncs stay aligned with the pixel pipeline, and feeds the VGA DAC pins.

Parameters:
- COLS, 80, visible text columns
- ROWS, 30, visible text rows (8x16 glyphs, 640x480)
- CLK_PER_PIX, 4, clk_i cycles per pixel (100 MHz clk, 25 MHz pixel)
- SYNC_IDLE, 1'b1, inactive level of hsync_o/vsync_o (active-low syncs)

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- col_stb_i  in  1  one-cycle pulse at start of each character cell (from CRTC)
- col_i  in  7  character column of current cell
- line_i  in  9  scanline; row=line_i[8:4], glyph scan=line_i[3:0]
- cursor_i  in  1  cursor blink phase from CRTC (1 = cursor shown)
- hsync_i  in  1  CRTC hsync
- vsync_i  in  1  CRTC vsync
- video_on_i  in  1  CRTC active-video flag
- cur_col_i  in  7  cursor column
- cur_row_i  in  5  cursor row
- vram_addr_o  out  12  video RAM word address
- vram_rd_o  out  1  video RAM read enable
- vram_data_i  in  16  [7:0] char code, [11:8] fg index, [15:12] bg index; synchronous, 1-cycle latency
- font_addr_o  out  12  {char[7:0], scan[3:0]}
- font_data_i  in  8  glyph row, bit7 = leftmost pixel; synchronous, 1-cycle latency
- rgb_o  out  12  {R[3:0],G[3:0],B[3:0]}
- hsync_o  out  1  hsync delayed to align with rgb_o
- vsync_o  out  1  vsync delayed to align with rgb_o

Behaviour:
- Reset (async assert, sync-released use): rgb_o=0, vram_rd_o=0, vram_addr_o=0, font_addr_o=0, hsync_o=vsync_o=SYNC_IDLE, all pipeline valid bits=0, shift reg=0.
- Pipeline, with E0 = the edge sampling col_stb_i=1:
  - E0: register vram_addr_o = row*80+col_i, computed as (row<<6)+(row<<4)+col. Register vram_rd_o=1 only if col_i<COLS and row<ROWS, else 0. Capture scan, cell-visible flag, cursor-hit flag (col_i==cur_col_i && row==cur_row_i && cursor_i && scan>=14).
  - E1: RAM data appears.
  - E2: register attr (fg,bg) and font_addr_o={vram_data_i[7:0],scan}. If the cell is not visible, force attr=0.
  - E3: ROM data appears.
  - E4: load 8-bit shift reg from font_data_i; if cursor-hit, load ~font_data_i (inverted). Clear pixel counter. Register rgb_o from the current MSB.
  - Net latency: col_stb_i to first pixel on rgb_o is 4 clocks.
- Pixel serialisation:
  - Shift left every CLK_PER_PIX clocks.
  - rgb_o = PALETTE[fg] when bit=1, PALETTE[bg] when bit=0.
  - After the 8th pixel, hold bg colour until the next load.
- hsync_o, vsync_o and video_on are delayed by a 4-stage shift register. rgb_o=0 whenever delayed video_on=0, overriding palette output.
- vram_rd_o is a one-cycle pulse (high only in the cycle after E0).
- A new col_stb_i arriving while a cell is still serialising restarts the pipeline for that cell. The E4 load wins over an in-progress shift.
- col_stb_i during blanking still runs the pipeline; output is black because of the video_on gate.
- Row/scan decode is purely from line_i; no internal frame counter.
- Reset mid-cell: the pipeline is discarded and the next col_stb_i after release starts clean.

Decomposition:
- Shared package `vga_pkg`: CGA 16-entry 12-bit PALETTE constant, COLS/ROWS/GLYPH_H=16/GLYPH_W=8 constants, attr field bit positions.
- One sub-module, `pixel_shifter`: shift reg + CLK_PER_PIX counter + fg/bg select.

Test Plan:
- Reset: hold rst_n_i=0 mid-stream -> rgb_o=0, hsync_o=vsync_o=1, vram_rd_o=0 immediately, without waiting for a clock edge.
- Address: col_i=5, line_i=35 (row 2), col_stb_i pulse -> next cycle vram_addr_o=165, vram_rd_o=1 for exactly 1 cycle.
- Glyph: vram_data_i=16'h1E41, font_data_i=8'b1000_0001, video_on_i=1 -> rgb_o changes 4 clocks after strobe:
  - pixel 0 = PALETTE[14], 4 clocks each;
  - pixels 1-6 = PALETTE[1];
  - pixel 7 = PALETTE[14].
- Cursor: cur_col_i=5, cur_row_i=2, cursor_i=1, line_i=46 (scan 14) -> inverted pattern (pixel 0 = PALETTE[1]). Same with cursor_i=0 -> normal pattern.
- Bounds/blank: col_i=85 -> vram_rd_o stays 0, rgb_o=bg of attr 0 (black). With video_on_i=0 -> rgb_o=0 regardless of font_data_i.
- Sync alignment: toggle hsync_i at an arbitrary edge -> hsync_o follows exactly 4 clocks later; same for vsync_i.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: text-mode geometry, CGA palette, attribute layout and cell pipeline types
package vga_pkg;
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int GLYPH_H = 16;
  localparam int GLYPH_W = 8;
  localparam int SCAN_W = $clog2(GLYPH_H);
  localparam int FG_LSB = 8;
  localparam int BG_LSB = 12;
  localparam logic [SCAN_W-1:0] CURSOR_SCAN = SCAN_W'(14);
  localparam logic [11:0] PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };
  typedef struct packed {
    logic v;
    logic [SCAN_W-1:0] scan;
    logic vis;
    logic hit;
  } front_t;
  typedef struct packed {
    logic v;
    logic hit;
    logic [3:0] fg;
    logic [3:0] bg;
  } back_t;
  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    cell_addr = ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};
  endfunction
endpackage

// File: rtl/pixel_shifter.sv
// pixel_shifter: glyph row serialiser with per-pixel clock divider and fg/bg palette lookup
module pixel_shifter
  import vga_pkg::*;
#(
  parameter int CLK_PER_PIX = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic [GLYPH_W-1:0] glyph_i,
  input  logic [3:0]         fg_i,
  input  logic [3:0]         bg_i,
  input  logic               von_i,
  output logic [11:0]        rgb_o
);
  localparam int CW = CLK_PER_PIX > 1 ? $clog2(CLK_PER_PIX) : 1;
  logic [GLYPH_W-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] fg_q, fg_d, bg_q, bg_d;
  logic [11:0] rgb_q, rgb_d;
  logic tick;
  // zeros shift in behind the glyph, so the cell falls back to bg after pixel 7
  always_comb begin
    tick = cnt_q == CW'(CLK_PER_PIX - 1);
    sh_d = load_i ? glyph_i : tick ? sh_q << 1 : sh_q;
    cnt_d = (load_i || tick) ? '0 : cnt_q + 1'b1;
    fg_d = load_i ? fg_i : fg_q;
    bg_d = load_i ? bg_i : bg_q;
    rgb_d = von_i ? PALETTE[sh_d[GLYPH_W-1] ? fg_d : bg_d] : 12'h000;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_q <= '0;
      cnt_q <= '0;
      fg_q <= '0;
      bg_q <= '0;
      rgb_q <= '0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      fg_q <= fg_d;
      bg_q <= bg_d;
      rgb_q <= rgb_d;
    end
  end
  assign rgb_o = rgb_q;
endmodule

// File: rtl/text_pixel_gen.sv
// text_pixel_gen: per-cell VRAM/font fetch pipeline feeding the pixel shifter, with aligned syncs
module text_pixel_gen
  import vga_pkg::*;
#(
  parameter int   COLS        = TEXT_COLS,
  parameter int   ROWS        = TEXT_ROWS,
  parameter int   CLK_PER_PIX = 4,
  parameter logic SYNC_IDLE   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        col_stb_i,
  input  logic [6:0]  col_i,
  input  logic [8:0]  line_i,
  input  logic        cursor_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        video_on_i,
  input  logic [6:0]  cur_col_i,
  input  logic [4:0]  cur_row_i,
  output logic [11:0] vram_addr_o,
  output logic        vram_rd_o,
  input  logic [15:0] vram_data_i,
  output logic [11:0] font_addr_o,
  input  logic [7:0]  font_data_i,
  output logic [11:0] rgb_o,
  output logic        hsync_o,
  output logic        vsync_o
);
  logic [4:0] row;
  logic [SCAN_W-1:0] scan;
  logic vis, hit;
  front_t [1:0] fr_q, fr_d;
  back_t [1:0] bk_q, bk_d;
  logic [11:0] vram_addr_q, vram_addr_d, font_addr_q, font_addr_d;
  logic vram_rd_q, vram_rd_d;
  logic [3:0] hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d, von_dly_q, von_dly_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic [GLYPH_W-1:0] glyph;
  assign row = line_i[8:4];
  assign scan = line_i[3:0];
  // fr_* tracks a cell while VRAM is read, bk_* while the font ROM is read
  always_comb begin
    vis = int'(col_i) < COLS && int'(row) < ROWS;
    hit = cursor_i && col_i == cur_col_i && row == cur_row_i && scan >= CURSOR_SCAN;
    fr_d[0] = '{v: col_stb_i, scan: scan, vis: vis, hit: hit};
    fr_d[1] = fr_q[0];
    bk_d[0] = '{v: fr_q[1].v, hit: fr_q[1].hit,
                fg: fr_q[1].vis ? vram_data_i[FG_LSB+:4] : 4'd0,
                bg: fr_q[1].vis ? vram_data_i[BG_LSB+:4] : 4'd0};
    bk_d[1] = bk_q[0];
    vram_addr_d = col_stb_i ? cell_addr(row, col_i) : vram_addr_q;
    vram_rd_d = col_stb_i && vis;
    font_addr_d = fr_q[1].v ? {vram_data_i[7:0], fr_q[1].scan} : font_addr_q;
    hs_dly_d = {hs_dly_q[2:0], hsync_i};
    vs_dly_d = {vs_dly_q[2:0], vsync_i};
    von_dly_d = {von_dly_q[2:0], video_on_i};
    hsync_d = hs_dly_q[3];
    vsync_d = vs_dly_q[3];
    glyph = bk_q[1].hit ? ~font_data_i : font_data_i;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fr_q <= '0;
      bk_q <= '0;
      vram_addr_q <= '0;
      vram_rd_q <= 1'b0;
      font_addr_q <= '0;
      hs_dly_q <= {4{SYNC_IDLE}};
      vs_dly_q <= {4{SYNC_IDLE}};
      von_dly_q <= '0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
    end else begin
      fr_q <= fr_d;
      bk_q <= bk_d;
      vram_addr_q <= vram_addr_d;
      vram_rd_q <= vram_rd_d;
      font_addr_q <= font_addr_d;
      hs_dly_q <= hs_dly_d;
      vs_dly_q <= vs_dly_d;
      von_dly_q <= von_dly_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end
  pixel_shifter #(.CLK_PER_PIX(CLK_PER_PIX)) u_shift (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (bk_q[1].v),
    .glyph_i (glyph),
    .fg_i    (bk_q[1].fg),
    .bg_i    (bk_q[1].bg),
    .von_i   (von_dly_q[3]),
    .rgb_o   (rgb_o)
  );
  assign vram_addr_o = vram_addr_q;
  assign vram_rd_o = vram_rd_q;
  assign font_addr_o = font_addr_q;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
endmodule

// File: tb/tb_text_pixel_gen.sv
// tb_text_pixel_gen: random CRTC stimulus against a cycle-indexed model of cell timing and colours
module tb_text_pixel_gen;
  localparam int CPP = 4;
  localparam int N = 8192;
  logic clk_i = 0, rst_n_i = 0, col_stb_i = 0, cursor_i = 0;
  logic hsync_i = 1, vsync_i = 1, video_on_i = 0;
  logic [6:0] col_i = 0, cur_col_i = 0;
  logic [8:0] line_i = 0;
  logic [4:0] cur_row_i = 0;
  logic [15:0] vram_data_i = 0;
  logic [7:0] font_data_i = 0;
  logic [11:0] vram_addr_o, font_addr_o, rgb_o;
  logic vram_rd_o, hsync_o, vsync_o;

  text_pixel_gen dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .col_stb_i(col_stb_i), .col_i(col_i), .line_i(line_i),
    .cursor_i(cursor_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .video_on_i(video_on_i),
    .cur_col_i(cur_col_i), .cur_row_i(cur_row_i), .vram_addr_o(vram_addr_o), .vram_rd_o(vram_rd_o),
    .vram_data_i(vram_data_i), .font_addr_o(font_addr_o), .font_data_i(font_data_i),
    .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 clk_i = ~clk_i;

  logic [15:0] vram [4096];
  logic [7:0] font [4096];
  always @(posedge clk_i) begin
    if (vram_rd_o) vram_data_i <= vram[vram_addr_o];
    font_data_i <= font[font_addr_o];
  end

  logic [11:0] pal [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  // history indexed by the clock edge (counted from reset release) that sampled the inputs
  logic h_stb [N], h_vis [N], h_hs [N], h_vs [N], h_von [N];
  int h_addr [N];
  logic [3:0] h_fg [N], h_bg [N], h_scan [N];
  logic [7:0] h_pat [N];
  int t, checks, failures;
  logic hs_v = 1, vs_v = 1, von_v = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, t, act, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < N; i++) begin
      h_stb[i] = 0; h_vis[i] = 0; h_hs[i] = 1; h_vs[i] = 1; h_von[i] = 0;
    end
    t = 0;
  endtask

  task automatic check_all();
    int s, k, e;
    logic b;
    chk("hsync", hsync_o, t > 4 ? int'(h_hs[t-4]) : 1);
    chk("vsync", vsync_o, t > 4 ? int'(h_vs[t-4]) : 1);
    e = 0;
    if (t > 4 && h_von[t-4]) begin
      s = t - 4;
      while (s >= 1 && !h_stb[s]) s--;
      if (s >= 1) begin
        k = (t - s - 4) / CPP;
        b = k < 8 ? h_pat[s][7-k] : 1'b0;
        e = pal[b ? h_fg[s] : h_bg[s]];
      end
    end
    chk("rgb", rgb_o, e);
    chk("vram_rd", vram_rd_o, h_stb[t] && h_vis[t]);
    s = t;
    while (s >= 1 && !h_stb[s]) s--;
    chk("vram_addr", vram_addr_o, s >= 1 ? h_addr[s] : 0);
    s = t - 2;
    while (s >= 1 && !h_stb[s]) s--;
    if (s < 1) chk("font_addr", font_addr_o, 0);
    else if (h_vis[s]) chk("font_addr", font_addr_o, int'({vram[h_addr[s]][7:0], h_scan[s]}));
  endtask

  task automatic drive(input logic stb, input int col, input int line, input logic cur,
                       input int cc, input int cr, input logic hs, input logic vs, input logic von);
    int n, row, scan, a;
    logic [7:0] g;
    n = t + 1;
    col_stb_i = stb; col_i = 7'(col); line_i = 9'(line); cursor_i = cur;
    cur_col_i = 7'(cc); cur_row_i = 5'(cr); hsync_i = hs; vsync_i = vs; video_on_i = von;
    h_stb[n] = stb; h_hs[n] = hs; h_vs[n] = vs; h_von[n] = von;
    row = line / 16;
    scan = line % 16;
    a = row * 80 + col;
    h_vis[n] = col < 80 && row < 30;
    h_addr[n] = a;
    h_scan[n] = 4'(scan);
    if (h_vis[n]) begin
      h_fg[n] = vram[a][11:8];
      h_bg[n] = vram[a][15:12];
      g = font[vram[a][7:0] * 16 + scan];
    end else begin
      h_fg[n] = 0; h_bg[n] = 0; g = 0;
    end
    h_pat[n] = (col == cc && row == cr && cur && scan >= 14) ? ~g : g;
  endtask

  task automatic step();
    @(posedge clk_i);
    t++;
    @(negedge clk_i);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(0, 0, 0, 0, 0, 0, hs_v, vs_v, von_v);
      step();
    end
  endtask

  task automatic release_reset();
    clear_hist();
    drive(0, 0, 0, 0, 0, 0, hs_v, vs_v, von_v);
    rst_n_i = 1;
    step();
  endtask

  initial begin
    int col, line, cc, cr;
    logic stb, cur;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 4096; i++) begin
      vram[i] = 16'($urandom);
      font[i] = 8'($urandom);
    end
    vram[165] = 16'h1E41;
    font[16'h41 * 16 + 3] = 8'h81;
    font[16'h41 * 16 + 14] = 8'h81;
    repeat (3) @(negedge clk_i);
    release_reset();
    von_v = 1;
    idle(6);
    // col 5, row 2, scan 3: fg 14 / bg 1 glyph 1000_0001
    drive(1, 5, 35, 0, 0, 0, hs_v, vs_v, von_v);
    step();
    chk("addr_lit", vram_addr_o, 165);
    chk("rd_lit", vram_rd_o, 1);
    idle(1);
    chk("rd_pulse_lit", vram_rd_o, 0);
    idle(3);
    chk("pix0_lit", rgb_o, 'hFF5);
    idle(4);
    chk("pix1_lit", rgb_o, 'h00A);
    idle(24);
    chk("pix7_lit", rgb_o, 'hFF5);
    idle(4);
    chk("hold_bg_lit", rgb_o, 'h00A);
    drive(1, 5, 46, 1, 5, 2, hs_v, vs_v, von_v);
    step();
    idle(4);
    chk("cursor_pix0_lit", rgb_o, 'h00A);
    idle(4);
    chk("cursor_pix1_lit", rgb_o, 'hFF5);
    idle(30);
    drive(1, 5, 46, 0, 5, 2, hs_v, vs_v, von_v);
    step();
    idle(4);
    chk("nocursor_pix0_lit", rgb_o, 'hFF5);
    idle(30);
    drive(1, 85, 35, 0, 0, 0, hs_v, vs_v, von_v);
    step();
    chk("oob_rd_lit", vram_rd_o, 0);
    idle(4);
    chk("oob_rgb_lit", rgb_o, 0);
    von_v = 0;
    drive(1, 5, 35, 0, 0, 0, hs_v, vs_v, von_v);
    step();
    idle(4);
    chk("blank_rgb_lit", rgb_o, 0);
    von_v = 1;
    idle(8);
    hs_v = 0;
    idle(4);
    chk("hsync_hold_lit", hsync_o, 1);
    idle(1);
    chk("hsync_edge_lit", hsync_o, 0);
    hs_v = 1;
    vs_v = 0;
    idle(4);
    chk("vsync_hold_lit", vsync_o, 1);
    idle(1);
    chk("vsync_edge_lit", vsync_o, 0);
    vs_v = 1;
    idle(8);
    // reset in the middle of a visible cell with syncs active
    hs_v = 0;
    vs_v = 0;
    drive(1, 5, 35, 0, 0, 0, hs_v, vs_v, von_v);
    step();
    idle(5);
    chk("pre_reset_rgb_lit", rgb_o, 'hFF5);
    rst_n_i = 0;
    #1;
    chk("reset_rgb", rgb_o, 0);
    chk("reset_hsync", hsync_o, 1);
    chk("reset_vsync", vsync_o, 1);
    chk("reset_rd", vram_rd_o, 0);
    chk("reset_vram_addr", vram_addr_o, 0);
    chk("reset_font_addr", font_addr_o, 0);
    repeat (3) @(negedge clk_i);
    hs_v = 1;
    vs_v = 1;
    release_reset();
    idle(4);
    repeat (3000) begin
      stb = $urandom_range(0, 5) == 0;
      col = $urandom_range(0, 87);
      line = $urandom_range(0, 511);
      cur = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        cc = col;
        cr = line / 16;
      end else begin
        cc = $urandom_range(0, 127);
        cr = $urandom_range(0, 31);
      end
      if ($urandom_range(0, 15) == 0) hs_v = ~hs_v;
      if ($urandom_range(0, 15) == 0) vs_v = ~vs_v;
      if ($urandom_range(0, 7) == 0) von_v = ~von_v;
      drive(stb, col, line, cur, cc, cr, hs_v, vs_v, von_v);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
